gpio_port: RTL and testbench

- Parametrised general-purpose I/O port on the 0x2000–0x20FF register bus.
- Generalises the fixed two-register dir/data latch used for the EEPROM pins to NUM_PINS channels.
- Adds input synchronisers, per-pin edge-detect interrupts with W1C pending flags, and an OR-able read bus.
- Sits beside the timers/irq controller; its irq output feeds one irq-controller source.

---
 rtl/minx_bus_pkg.sv | 38 +++
 rtl/gpio_pin_in.sv | 87 ++++++++
 rtl/gpio_port.sv | 140 ++++++++++++++
 tb/tb_gpio_port.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/minx_bus_pkg.sv
// minx_bus_pkg
//   Shared definitions for peripherals on the 0x2000-0x20FF register bus:
//   bus command encodings, the register window bounds and the GPIO
//   register offsets (relative to a block's base address).
//   No ports (package).
package minx_bus_pkg;

  typedef enum logic [1:0] {
    BUS_COMMAND_IDLE  = 2'b00,
    BUS_COMMAND_READ  = 2'b01,
    BUS_COMMAND_WRITE = 2'b10
  } bus_command_e;

  localparam logic [23:0] REG_WINDOW_LO = 24'h2000;
  localparam logic [23:0] REG_WINDOW_HI = 24'h2100;

  typedef enum logic [2:0] {
    GPIO_REG_DIR      = 3'd0,
    GPIO_REG_DATA     = 3'd1,
    GPIO_REG_IRQ_EN   = 3'd2,
    GPIO_REG_IRQ_EDGE = 3'd3,
    GPIO_REG_PEND     = 3'd4
  } gpio_reg_e;

  localparam int GPIO_NUM_REGS = 5;

  // Write wins if a master ever raises both strobes together.
  function automatic bus_command_e bus_command(input logic write, input logic read);
    if (write)     return BUS_COMMAND_WRITE;
    else if (read) return BUS_COMMAND_READ;
    else           return BUS_COMMAND_IDLE;
  endfunction

  function automatic logic in_reg_window(input logic [23:0] addr);
    return (addr >= REG_WINDOW_LO) && (addr < REG_WINDOW_HI);
  endfunction

endpackage

// File: rtl/gpio_pin_in.sv
// gpio_pin_in
//   Input path for one GPIO pad: SYNC_STAGES-deep synchroniser, optional
//   debouncer (macro GPIO_DEBOUNCE_EN), and a history flop that yields
//   single-tick rise/fall pulses. All state advances only on clk_ce.
// Ports:
//   clk, reset (async, active low), clk_ce
//   pin    : asynchronous pad input
//   level  : synchronised (and, if enabled, debounced) pin value
//   rise   : level is 1 and was 0 on the previous ce tick
//   fall   : level is 0 and was 1 on the previous ce tick
module gpio_pin_in
  import minx_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_ce,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else if (clk_ce) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  // Down-counter reloads whenever the synchronised input agrees with the
  // debounced value; reaching zero on the DEBOUNCE_CYCLES-th consecutive
  // mismatching tick commits the new level.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             deb_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q <= 1'b0;
      cnt_q <= CNT_LOAD;
    end else if (clk_ce) begin
      if (sync_out == deb_q) begin
        cnt_q <= CNT_LOAD;
      end else if (cnt_q == '0) begin
        deb_q <= sync_out;
        cnt_q <= CNT_LOAD;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign level = deb_q;
`else
  assign level = sync_out;
`endif

  // History tracks the level on every tick, including while the pin is an
  // output, so turning a pin back into an input never sees stale history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= 1'b0;
    end else if (clk_ce) begin
      hist_q <= level;
    end
  end

  assign rise = level & ~hist_q;
  assign fall = ~level & hist_q;

endmodule

// File: rtl/gpio_port.sv
// gpio_port
//   NUM_PINS-channel GPIO on the register bus at BASE_ADDR..BASE_ADDR+4:
//     +0 DIR (1=output)  +1 DATA  +2 IRQ_EN  +3 IRQ_EDGE (0 rise, 1 fall)
//     +4 IRQ_PEND (write 1 to clear)
//   Optional macro GPIO_DEBOUNCE_EN inserts a per-pin debouncer after the
//   synchroniser; without it DEBOUNCE_CYCLES has no effect on the pin path.
// Ports:
//   clk, reset (async, active low), clk_ce (all state advances only when high)
//   bus_write, bus_read, bus_address_in[23:0], bus_data_in[7:0]
//   bus_data_out[7:0] : combinational read data, 0 when not decoded
//   pins_in           : asynchronous pad inputs
//   pins_out, pins_oe : output latch and output enable (= DIR)
//   irq               : registered level interrupt, |(IRQ_PEND & IRQ_EN)
module gpio_port
  import minx_bus_pkg::*;
#(
  parameter int          NUM_PINS        = 8,
  parameter logic [23:0] BASE_ADDR       = 24'h2060,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_ce,
  input  logic                bus_write,
  input  logic                bus_read,
  input  logic [23:0]         bus_address_in,
  input  logic [7:0]          bus_data_in,
  output logic [7:0]          bus_data_out,
  input  logic [NUM_PINS-1:0] pins_in,
  output logic [NUM_PINS-1:0] pins_out,
  output logic [NUM_PINS-1:0] pins_oe,
  output logic                irq
);

`ifdef GPIO_DEBOUNCE_EN
  localparam bit DEBOUNCE_ON = 1'b1;
`else
  localparam bit DEBOUNCE_ON = 1'b0;
`endif

  // Edge detection stays off until the input path has settled after reset,
  // including the debouncer when present, so a pin held high across reset
  // does not look like a rising edge.
  localparam int WARM_TICKS = SYNC_STAGES + 1 + (DEBOUNCE_ON ? DEBOUNCE_CYCLES : 0);
  localparam int WARM_W     = $clog2(WARM_TICKS + 1);
  localparam logic [WARM_W-1:0] WARM_DONE_CNT = WARM_W'(WARM_TICKS);

  logic [NUM_PINS-1:0] dir_q, data_q, en_q, edge_q, pend_q;
  logic                irq_q;
  logic [WARM_W-1:0]   warm_cnt_q;
  logic                warm_done;

  logic [NUM_PINS-1:0] level, rise, fall;
  logic [NUM_PINS-1:0] edge_hit, pend_set, pend_clr, pend_d;
  logic [NUM_PINS-1:0] wdata, rd_val;

  logic [23:0]  addr_off;
  logic         hit;
  gpio_reg_e    reg_sel;
  bus_command_e bus_cmd;
  logic         wr_en;

  // Address decode
  assign addr_off = bus_address_in - BASE_ADDR;
  assign hit      = in_reg_window(bus_address_in)
                    && (bus_address_in >= BASE_ADDR)
                    && (addr_off < 24'(GPIO_NUM_REGS));
  assign reg_sel  = gpio_reg_e'(addr_off[2:0]);
  assign bus_cmd  = bus_command(bus_write, bus_read);
  assign wr_en    = clk_ce && hit && (bus_cmd == BUS_COMMAND_WRITE);
  assign wdata    = bus_data_in[NUM_PINS-1:0];

  // Per-pin input path
  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    gpio_pin_in #(
      .SYNC_STAGES    (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
      ,
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
    ) u_pin_in (
      .clk   (clk),
      .reset (reset),
      .clk_ce(clk_ce),
      .pin   (pins_in[g]),
      .level (level[g]),
      .rise  (rise[g]),
      .fall  (fall[g])
    );
  end

  assign warm_done = (warm_cnt_q == WARM_DONE_CNT);

  // Output pins never raise pending flags. A same-tick set beats the W1C.
  assign edge_hit = (edge_q & fall) | (~edge_q & rise);
  assign pend_set = warm_done ? (edge_hit & ~dir_q) : '0;
  assign pend_clr = (wr_en && reg_sel == GPIO_REG_PEND) ? wdata : '0;
  assign pend_d   = (pend_q & ~pend_clr) | pend_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q      <= '0;
      data_q     <= '0;
      en_q       <= '0;
      edge_q     <= '0;
      pend_q     <= '0;
      irq_q      <= 1'b0;
      warm_cnt_q <= '0;
    end else if (clk_ce) begin
      if (wr_en && reg_sel == GPIO_REG_DIR)      dir_q  <= wdata;
      if (wr_en && reg_sel == GPIO_REG_DATA)     data_q <= wdata;
      if (wr_en && reg_sel == GPIO_REG_IRQ_EN)   en_q   <= wdata;
      if (wr_en && reg_sel == GPIO_REG_IRQ_EDGE) edge_q <= wdata;
      pend_q <= pend_d;
      irq_q  <= |(pend_q & en_q);
      if (!warm_done) warm_cnt_q <= warm_cnt_q + 1'b1;
    end
  end

  // Read mux; DATA shows the latch for outputs and the pad level for inputs.
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      GPIO_REG_DIR:      rd_val = dir_q;
      GPIO_REG_DATA:     rd_val = (dir_q & data_q) | (~dir_q & level);
      GPIO_REG_IRQ_EN:   rd_val = en_q;
      GPIO_REG_IRQ_EDGE: rd_val = edge_q;
      GPIO_REG_PEND:     rd_val = pend_q;
      default:           rd_val = '0;
    endcase
    bus_data_out = '0;
    if (hit) bus_data_out[NUM_PINS-1:0] = rd_val;
  end

  assign pins_out = data_q;
  assign pins_oe  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_port.sv
module tb_gpio_port;

  localparam logic [23:0] BASE = 24'h2060;
  localparam int SYNC = 2;
  localparam int DEB  = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT  = SYNC + DEB;
  localparam int WARM = SYNC + 1 + DEB;
`else
  localparam int LAT  = SYNC;
  localparam int WARM = SYNC + 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_ce;
  logic        bus_write, bus_read;
  logic [23:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  pins8;
  logic [3:0]  pins4;
  logic [7:0]  rdata8, rdata4;
  logic [7:0]  out8, oe8;
  logic [3:0]  out4, oe4;
  logic        irq8, irq4;

  int n_checks = 0;
  int n_fail   = 0;

  assign pins4 = pins8[3:0];

  always #5 clk = ~clk;

  gpio_port #(.NUM_PINS(8), .BASE_ADDR(BASE), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut8 (
    .clk(clk), .reset(rst_n), .clk_ce(clk_ce), .bus_write(bus_write), .bus_read(bus_read),
    .bus_address_in(bus_addr), .bus_data_in(bus_wdata), .bus_data_out(rdata8),
    .pins_in(pins8), .pins_out(out8), .pins_oe(oe8), .irq(irq8));

  gpio_port #(.NUM_PINS(4), .BASE_ADDR(BASE), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut4 (
    .clk(clk), .reset(rst_n), .clk_ce(clk_ce), .bus_write(bus_write), .bus_read(bus_read),
    .bus_address_in(bus_addr), .bus_data_in(bus_wdata), .bus_data_out(rdata4),
    .pins_in(pins4), .pins_out(out4), .pins_oe(oe4), .irq(irq4));

  typedef struct {
    logic        wr;
    logic [23:0] waddr;
    logic [7:0]  wdata;
    logic [7:0]  pins;
    logic [23:0] raddr;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_oe;
    logic [7:0]  exp_out;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [23:0] a, input logic [7:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_write = 1'b1;
    tick(1);
    bus_write = 1'b0;
  endtask

  task automatic rd(input logic [23:0] a, output logic [7:0] v8, output logic [7:0] v4);
    bus_addr = a;
    bus_read = 1'b1;
    #1;
    v8 = rdata8;
    v4 = rdata4;
    bus_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r8, r4;
    int lat;

    //            wr    waddr       wdata  pins   raddr       rd     oe     out    irq
    vecs[0] = '{1'b1, BASE+24'd0, 8'h0F, 8'hFF, BASE+24'd0, 8'h0F, 8'h0F, 8'h00, 1'b0};
    vecs[1] = '{1'b1, BASE+24'd1, 8'hA5, 8'hFF, BASE+24'd1, 8'hF5, 8'h0F, 8'hA5, 1'b0};
    vecs[2] = '{1'b0, 24'h0,      8'h00, 8'h30, BASE+24'd1, 8'h35, 8'h0F, 8'hA5, 1'b0};
    vecs[3] = '{1'b1, BASE+24'd2, 8'h3C, 8'h30, BASE+24'd2, 8'h3C, 8'h0F, 8'hA5, 1'b0};
    vecs[4] = '{1'b1, BASE+24'd3, 8'hF0, 8'h30, BASE+24'd3, 8'hF0, 8'h0F, 8'hA5, 1'b0};
    vecs[5] = '{1'b1, BASE+24'd5, 8'hFF, 8'h30, BASE+24'd5, 8'h00, 8'h0F, 8'hA5, 1'b0};
    vecs[6] = '{1'b0, 24'h0,      8'h00, 8'h30, BASE-24'd1, 8'h00, 8'h0F, 8'hA5, 1'b0};
    vecs[7] = '{1'b1, BASE+24'd0, 8'hFF, 8'h30, BASE+24'd0, 8'hFF, 8'hFF, 8'hA5, 1'b0};
    vecs[8] = '{1'b1, BASE+24'd0, 8'h00, 8'h30, BASE+24'd1, 8'h30, 8'h00, 8'hA5, 1'b0};
    vecs[9] = '{1'b0, 24'h0,      8'h00, 8'h30, BASE+24'd4, 8'h00, 8'h00, 8'hA5, 1'b0};

    rst_n = 1'b0; clk_ce = 1'b1; bus_write = 1'b0; bus_read = 1'b0;
    bus_addr = 24'h0; bus_wdata = 8'h00; pins8 = 8'hFF;

    // Reset state with all pins held high
    tick(2);
    chk("rst_oe8", oe8, 8'h00);
    chk("rst_out8", out8, 8'h00);
    chk("rst_irq8", {7'd0, irq8}, 8'h00);
    rd(BASE + 24'd0, r8, r4);
    chk("rst_dir8", r8, 8'h00);
    rd(BASE + 24'd1, r8, r4);
    chk("rst_data8", r8, 8'h00);

    rst_n = 1'b1;
    tick(LAT - 1);
    rd(BASE + 24'd1, r8, r4);
    chk("sync_early8", r8, 8'h00);
    tick(1);
    rd(BASE + 24'd1, r8, r4);
    chk("sync_lat8", r8, 8'hFF);
    chk("sync_lat4", r4, 8'h0F);
    tick(WARM + 8);
    rd(BASE + 24'd4, r8, r4);
    chk("warm_pend8", r8, 8'h00);
    chk("warm_pend4", r4, 8'h00);
    chk("warm_irq8", {7'd0, irq8}, 8'h00);

    // Register table
    for (int i = 0; i < 10; i++) begin
      pins8 = vecs[i].pins;
      if (vecs[i].wr) bus_wr(vecs[i].waddr, vecs[i].wdata);
      else tick(1);
      tick(LAT + 1);
      rd(vecs[i].raddr, r8, r4);
      chk($sformatf("vec%0d_rd8", i), r8, vecs[i].exp_rd);
      chk($sformatf("vec%0d_rd4", i), r4, vecs[i].exp_rd & 8'h0F);
      chk($sformatf("vec%0d_oe8", i), oe8, vecs[i].exp_oe);
      chk($sformatf("vec%0d_out8", i), out8, vecs[i].exp_out);
      chk($sformatf("vec%0d_oe4", i), {4'd0, oe4}, vecs[i].exp_oe & 8'h0F);
      chk($sformatf("vec%0d_out4", i), {4'd0, out4}, vecs[i].exp_out & 8'h0F);
      chk($sformatf("vec%0d_irq8", i), {7'd0, irq8}, {7'd0, vecs[i].exp_irq});
    end

    // Rising edge on pin 0, then W1C
    bus_wr(BASE + 24'd2, 8'h01);
    bus_wr(BASE + 24'd3, 8'h00);
    pins8 = 8'h31;
    tick(LAT);
    rd(BASE + 24'd4, r8, r4);
    chk("rise_pend_early8", r8, 8'h00);
    tick(1);
    rd(BASE + 24'd4, r8, r4);
    chk("rise_pend8", r8, 8'h01);
    chk("rise_pend4", r4, 8'h01);
    chk("rise_irq_early8", {7'd0, irq8}, 8'h00);
    tick(1);
    chk("rise_irq8", {7'd0, irq8}, 8'h01);
    chk("rise_irq4", {7'd0, irq4}, 8'h01);
    bus_wr(BASE + 24'd4, 8'h01);
    rd(BASE + 24'd4, r8, r4);
    chk("w1c_pend8", r8, 8'h00);
    chk("w1c_irq_hold8", {7'd0, irq8}, 8'h01);
    tick(1);
    chk("w1c_irq8", {7'd0, irq8}, 8'h00);
    chk("w1c_irq4", {7'd0, irq4}, 8'h00);

    // Falling edge on pin 3 in the same tick as W1C of bit 3: set wins
    bus_wr(BASE + 24'd3, 8'h08);
    bus_wr(BASE + 24'd2, 8'h08);
    pins8 = 8'h39;
    tick(LAT + 2);
    rd(BASE + 24'd4, r8, r4);
    chk("fall_cfg_rise_ignored8", r8, 8'h00);
    pins8 = 8'h31;
    tick(LAT);
    bus_wr(BASE + 24'd4, 8'h08);
    rd(BASE + 24'd4, r8, r4);
    chk("set_wins_pend8", r8, 8'h08);
    chk("set_wins_pend4", r4, 8'h08);
    tick(1);
    chk("set_wins_irq8", {7'd0, irq8}, 8'h01);
    bus_wr(BASE + 24'd4, 8'h08);
    tick(1);
    rd(BASE + 24'd4, r8, r4);
    chk("clr_pend8", r8, 8'h00);
    chk("clr_irq8", {7'd0, irq8}, 8'h00);

    // Changing IRQ_EDGE with high inputs creates no edge
    bus_wr(BASE + 24'd3, 8'hFF);
    tick(LAT + 2);
    rd(BASE + 24'd4, r8, r4);
    chk("edge_write_no_pend8", r8, 8'h00);
    chk("edge_write_no_pend4", r4, 8'h00);
    bus_wr(BASE + 24'd3, 8'h00);

    // Clock enable low blocks writes
    clk_ce = 1'b0;
    bus_wr(BASE + 24'd0, 8'hFF);
    tick(2);
    chk("ce_low_oe8", oe8, 8'h00);
    clk_ce = 1'b1;
    tick(1);
    chk("ce_high_oe8", oe8, 8'h00);

    // Reset asserted mid-sequence clears everything immediately
    bus_wr(BASE + 24'd0, 8'h0F);
    bus_wr(BASE + 24'd1, 8'h55);
    bus_wr(BASE + 24'd2, 8'hFF);
    chk("pre_rst_oe8", oe8, 8'h0F);
    #2;
    rst_n = 1'b0;
    pins8 = 8'h00;
    #1;
    chk("mid_rst_oe8", oe8, 8'h00);
    chk("mid_rst_out8", out8, 8'h00);
    chk("mid_rst_oe4", {4'd0, oe4}, 8'h00);
    chk("mid_rst_out4", {4'd0, out4}, 8'h00);
    rd(BASE + 24'd2, r8, r4);
    chk("mid_rst_en8", r8, 8'h00);
    chk("mid_rst_en4", r4, 8'h00);
    rd(BASE + 24'd0, r8, r4);
    chk("mid_rst_dir8", r8, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(WARM + 4);

`ifdef GPIO_DEBOUNCE_EN
    // Short glitch is filtered; a long pulse gets through after DEB+SYNC ticks
    pins8 = 8'h01;
    tick(10);
    pins8 = 8'h00;
    tick(30);
    rd(BASE + 24'd4, r8, r4);
    chk("glitch_pend8", r8, 8'h00);
    pins8 = 8'h01;
    lat = -1;
    for (int t = 1; t <= 40; t++) begin
      tick(1);
      rd(BASE + 24'd1, r8, r4);
      if (r8[0] && lat < 0) lat = t;
    end
    chk("deb_lat8", 8'(lat), 8'(DEB + SYNC));
    rd(BASE + 24'd4, r8, r4);
    chk("deb_pend8", r8, 8'h01);
    pins8 = 8'h00;
`else
    lat = 0;
    pins8 = 8'h01;
    tick(LAT);
    rd(BASE + 24'd1, r8, r4);
    chk("post_rst_data8", r8, 8'h01);
    tick(1);
    rd(BASE + 24'd4, r8, r4);
    chk("post_rst_pend8", r8, 8'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
